nabp_sinogram_line_fetcher: RTL and testbench

Requesting end of the angle/sinogram-address protocol. The block drives `fr_next_angle` and `fr_s_val` into the sinogram addresser, sweeps one projection line per acknowledged angle, and captures the sinogram RAM read data into an internal double-buffered line store. The processing swappable then reads each filled line by s index and releases it, so line fetch overlaps with back-projection of the previous angle.

---
 rtl/nabp_sinogram_line_fetcher.sv | 174 +++++++++++++++++
 tb/tb_nabp_sinogram_line_fetcher.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nabp_sinogram_line_fetcher.sv
// Fetches one sinogram projection line per acknowledged angle into a
// double-buffered line store that the back-projection side reads by s index.
module nabp_sinogram_line_fetcher #(
  parameter int S_LENGTH        = 9,
  parameter int ANGLE_LENGTH    = 12,
  parameter int DATA_WIDTH      = 16,
  parameter int LINE_SIZE       = 256,
  parameter int SG_READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    hs_kick,
  input  logic [ANGLE_LENGTH-1:0] sa_angle,
  input  logic                    sa_has_next_angle,
  input  logic                    sa_next_angle_ack,
  output logic                    fr_next_angle,
  output logic [S_LENGTH-1:0]     fr_s_val,
  input  logic [DATA_WIDTH-1:0]   sg_data,
  output logic                    pr_line_valid,
  output logic [ANGLE_LENGTH-1:0] pr_angle,
  input  logic [S_LENGTH-1:0]     pr_s_addr,
  output logic [DATA_WIDTH-1:0]   pr_data,
  input  logic                    pr_line_done,
  output logic                    all_done
);

  localparam int IDX_W = (LINE_SIZE > 1) ? $clog2(LINE_SIZE) : 1;
  localparam logic [S_LENGTH-1:0] S_LAST     = S_LENGTH'(LINE_SIZE - 1);
  localparam logic [S_LENGTH:0]   S_SIZE     = (S_LENGTH + 1)'(LINE_SIZE);
  localparam logic [2:0]          DRAIN_LAST = 3'(SG_READ_LATENCY - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_SWEEP = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  logic [2:0]              state;
  logic [2:0]              state_nxt;
  logic [1:0]              full;
  logic [1:0]              full_nxt;
  logic                    wr_bank;
  logic                    rd_bank;
  logic                    fetch_done;
  logic [ANGLE_LENGTH-1:0] angle0;
  logic [ANGLE_LENGTH-1:0] angle1;
  logic [S_LENGTH-1:0]     s_cnt;
  logic [2:0]              drain_cnt;
  logic                    sweep_last;
  logic                    drain_end;
  logic                    line_release;

  logic             cap_v [SG_READ_LATENCY];
  logic [IDX_W-1:0] cap_s [SG_READ_LATENCY];

  logic [DATA_WIDTH-1:0] line0 [LINE_SIZE];
  logic [DATA_WIDTH-1:0] line1 [LINE_SIZE];

  assign sweep_last   = (state == ST_SWEEP) && (s_cnt == S_LAST);
  assign drain_end    = (state == ST_DRAIN) && (drain_cnt == DRAIN_LAST);
  assign line_release = pr_line_done && full[rd_bank];

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (!full[wr_bank]) state_nxt = ST_REQ;
      ST_REQ: begin
        if (sa_next_angle_ack)       state_nxt = ST_WAIT;
        else if (!sa_has_next_angle) state_nxt = ST_DONE;
        else                         state_nxt = ST_IDLE;
      end
      ST_WAIT:  state_nxt = ST_SWEEP;
      ST_SWEEP: if (sweep_last) state_nxt = ST_DRAIN;
      ST_DRAIN: if (drain_end) state_nxt = ST_IDLE;
      ST_DONE:  if (hs_kick) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      s_cnt      <= '0;
      drain_cnt  <= '0;
      fetch_done <= 1'b0;
      wr_bank    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_REQ && !sa_next_angle_ack && !sa_has_next_angle)
        fetch_done <= 1'b1;
      else if (state == ST_DONE && hs_kick)
        fetch_done <= 1'b0;
      // s holds its last value outside SWEEP so fr_s_val stays stable
      if (state == ST_WAIT)
        s_cnt <= '0;
      else if (state == ST_SWEEP && !sweep_last)
        s_cnt <= s_cnt + 1'b1;
      if (state == ST_SWEEP)
        drain_cnt <= '0;
      else if (state == ST_DRAIN)
        drain_cnt <= drain_cnt + 1'b1;
      if (drain_end)
        wr_bank <= ~wr_bank;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      angle0 <= '0;
      angle1 <= '0;
    end else if (state == ST_WAIT) begin
      if (wr_bank) angle1 <= sa_angle;
      else         angle0 <= sa_angle;
    end
  end

  // Fill completion and release never target the same bank, so both apply.
  always_comb begin
    full_nxt = full;
    if (line_release) full_nxt[rd_bank] = 1'b0;
    if (drain_end)    full_nxt[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      full    <= '0;
      rd_bank <= 1'b0;
    end else begin
      full <= full_nxt;
      if (line_release)
        rd_bank <= ~rd_bank;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < SG_READ_LATENCY; i++) begin
        cap_v[i] <= 1'b0;
        cap_s[i] <= '0;
      end
    end else begin
      cap_v[0] <= (state == ST_SWEEP);
      cap_s[0] <= s_cnt[IDX_W-1:0];
      for (int unsigned i = 1; i < SG_READ_LATENCY; i++) begin
        cap_v[i] <= cap_v[i-1];
        cap_s[i] <= cap_s[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cap_v[SG_READ_LATENCY-1]) begin
      if (wr_bank) line1[cap_s[SG_READ_LATENCY-1]] <= sg_data;
      else         line0[cap_s[SG_READ_LATENCY-1]] <= sg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      pr_data <= '0;
    else if ({1'b0, pr_s_addr} < S_SIZE)
      pr_data <= rd_bank ? line1[pr_s_addr[IDX_W-1:0]] : line0[pr_s_addr[IDX_W-1:0]];
    else
      pr_data <= '0;
  end

  assign fr_next_angle = (state == ST_REQ);
  assign fr_s_val      = s_cnt;
  assign pr_line_valid = full[rd_bank];
  assign pr_angle      = rd_bank ? angle1 : angle0;
  assign all_done      = fetch_done && (full == 2'b00);

endmodule

// File: tb/tb_nabp_sinogram_line_fetcher.sv
// Directed bench: behavioural addresser + sinogram RAM around the line fetcher,
// plus two extra instances at read latencies 2 and 4.
`timescale 1ns/1ps
module tb_nabp_sinogram_line_fetcher;
  localparam int LS = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n = 1'b0;
  logic        hs_kick;
  logic [11:0] sa_angle;
  logic        sa_has_next_angle;
  logic        sa_next_angle_ack;
  logic        fr_next_angle;
  logic [8:0]  fr_s_val;
  logic [15:0] sg_data;
  logic        pr_line_valid;
  logic [11:0] pr_angle;
  logic [8:0]  pr_s_addr;
  logic [15:0] pr_data;
  logic        pr_line_done;
  logic        all_done;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  nabp_sinogram_line_fetcher #(.LINE_SIZE(LS), .SG_READ_LATENCY(1)) dut (
    .clk(clk), .reset_n(reset_n), .hs_kick(hs_kick),
    .sa_angle(sa_angle), .sa_has_next_angle(sa_has_next_angle),
    .sa_next_angle_ack(sa_next_angle_ack),
    .fr_next_angle(fr_next_angle), .fr_s_val(fr_s_val), .sg_data(sg_data),
    .pr_line_valid(pr_line_valid), .pr_angle(pr_angle), .pr_s_addr(pr_s_addr),
    .pr_data(pr_data), .pr_line_done(pr_line_done), .all_done(all_done)
  );

  // Addresser model: 4 angles (0,45,90,135), base = 8*index, first ack does not advance
  logic       ad_run = 1'b0;
  logic       ad_first = 1'b0;
  logic [1:0] ad_idx = 2'd0;
  logic       ad_last;

  always_comb begin
    ad_last           = ad_run && !ad_first && (ad_idx == 2'd3);
    sa_has_next_angle = !ad_last;
    sa_next_angle_ack = fr_next_angle && ad_run && !ad_last;
    sa_angle          = 12'(ad_idx) * 12'd45;
  end

  always @(posedge clk) begin
    if (!reset_n) begin
      ad_run <= 1'b0; ad_first <= 1'b0; ad_idx <= 2'd0;
    end else if (hs_kick) begin
      ad_run <= 1'b1; ad_first <= 1'b1; ad_idx <= 2'd0;
    end else if (fr_next_angle && ad_run) begin
      if (ad_last)       ad_run <= 1'b0;
      else if (ad_first) ad_first <= 1'b0;
      else               ad_idx <= ad_idx + 2'd1;
    end
    sg_data <= 16'(ad_idx) * 16'd8 + 16'(fr_s_val) + 16'd1;
  end

  int req_all = 0, req_run = 0, ack_cnt = 0, last_req_cyc = 0;
  int t_req = -1, t_val = -1;
  always @(posedge clk) begin
    if (reset_n) begin
      if (fr_next_angle) begin
        req_all <= req_all + 1;
        last_req_cyc <= cyc;
        if (ad_run) req_run <= req_run + 1;
      end
      if (sa_next_angle_ack) begin
        ack_cnt <= ack_cnt + 1;
        if (t_req < 0) t_req <= cyc;
      end
      if (pr_line_valid && t_val < 0) t_val <= cyc;
    end
  end

  // Latency-2 and latency-4 instances: always acked, RAM data = 3*s+5, never released
  logic [8:0]  aux_addr;
  logic        l2_req, l2_valid, l2_done, l4_req, l4_valid, l4_done;
  logic [8:0]  l2_sval, l4_sval;
  logic [11:0] l2_angle, l4_angle;
  logic [15:0] l2_data, l4_data, l2_prdata, l4_prdata;
  logic [8:0]  l2_pipe [2];
  logic [8:0]  l4_pipe [4];

  nabp_sinogram_line_fetcher #(.LINE_SIZE(LS), .SG_READ_LATENCY(2)) u_lat2 (
    .clk(clk), .reset_n(reset_n), .hs_kick(1'b0),
    .sa_angle(12'd7), .sa_has_next_angle(1'b1), .sa_next_angle_ack(l2_req),
    .fr_next_angle(l2_req), .fr_s_val(l2_sval), .sg_data(l2_data),
    .pr_line_valid(l2_valid), .pr_angle(l2_angle), .pr_s_addr(aux_addr),
    .pr_data(l2_prdata), .pr_line_done(1'b0), .all_done(l2_done)
  );

  nabp_sinogram_line_fetcher #(.LINE_SIZE(LS), .SG_READ_LATENCY(4)) u_lat4 (
    .clk(clk), .reset_n(reset_n), .hs_kick(1'b0),
    .sa_angle(12'd7), .sa_has_next_angle(1'b1), .sa_next_angle_ack(l4_req),
    .fr_next_angle(l4_req), .fr_s_val(l4_sval), .sg_data(l4_data),
    .pr_line_valid(l4_valid), .pr_angle(l4_angle), .pr_s_addr(aux_addr),
    .pr_data(l4_prdata), .pr_line_done(1'b0), .all_done(l4_done)
  );

  always @(posedge clk) begin
    l2_pipe[0] <= l2_sval;
    l2_pipe[1] <= l2_pipe[0];
    l4_pipe[0] <= l4_sval;
    for (int i = 1; i < 4; i++) l4_pipe[i] <= l4_pipe[i-1];
  end
  assign l2_data = 16'(l2_pipe[1]) * 16'd3 + 16'd5;
  assign l4_data = 16'(l4_pipe[3]) * 16'd3 + 16'd5;

  int l2_treq = -1, l2_tval = -1, l4_treq = -1, l4_tval = -1;
  always @(posedge clk) begin
    if (reset_n) begin
      if (l2_req && l2_treq < 0)   l2_treq <= cyc;
      if (l2_valid && l2_tval < 0) l2_tval <= cyc;
      if (l4_req && l4_treq < 0)   l4_treq <= cyc;
      if (l4_valid && l4_tval < 0) l4_tval <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic kick();
    hs_kick = 1'b1;
    @(negedge clk);
    hs_kick = 1'b0;
  endtask

  task automatic release_line();
    pr_line_done = 1'b1;
    @(negedge clk);
    pr_line_done = 1'b0;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!pr_line_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(pr_line_valid), 1);
  endtask

  task automatic read_line(input int base, input string tag);
    pr_s_addr = 9'd0;
    for (int i = 0; i < LS; i++) begin
      @(negedge clk);
      check($sformatf("%s[%0d]", tag, i), 32'(pr_data), 32'(base + i + 1));
      pr_s_addr = 9'(i + 1);
    end
  endtask

  task automatic consume_all(input string tag);
    int n;
    for (int k = 0; k < 4; k++) begin
      wait_valid($sformatf("%s_l%0d", tag, k));
      check($sformatf("%s_angle%0d", tag, k), 32'(pr_angle), 32'(45 * k));
      read_line(8 * k, $sformatf("%s_d%0d", tag, k));
      if (k == 3) check({tag, "_alldone_early"}, 32'(all_done), 0);
      release_line();
    end
    n = 0;
    while (!all_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_alldone"}, 32'(all_done), 1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req"},   32'(fr_next_angle), 0);
    check({tag, "_sval"},  32'(fr_s_val), 0);
    check({tag, "_valid"}, 32'(pr_line_valid), 0);
    check({tag, "_angle"}, 32'(pr_angle), 0);
    check({tag, "_data"},  32'(pr_data), 0);
    check({tag, "_done"},  32'(all_done), 0);
  endtask

  initial begin
    int base_all, base_run, base_ack, r, n;
    logic seen;
    hs_kick = 1'b0; pr_s_addr = '0; pr_line_done = 1'b0; aux_addr = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("rst");

    // Not kicked: requests retried every other cycle, nothing acknowledged
    reset_n = 1'b1;
    base_all = req_all; base_ack = ack_cnt;
    repeat (10) @(negedge clk);
    check("nokick_reqs",  32'(req_all - base_all), 5);
    check("nokick_acks",  32'(ack_cnt - base_ack), 0);
    check("nokick_valid", 32'(pr_line_valid), 0);
    check("nokick_sval",  32'(fr_s_val), 0);

    base_run = req_run;
    kick();
    consume_all("run1");
    check("run1_reqs", 32'(req_run - base_run), 5);
    check("lat1_fill", 32'(t_val - t_req), LS + 2 + 1);

    check("lat2_fill",  32'(l2_tval - l2_treq), LS + 2 + 2);
    check("lat4_fill",  32'(l4_tval - l4_treq), LS + 2 + 4);
    check("lat2_valid", 32'(l2_valid), 1);
    check("lat4_valid", 32'(l4_valid), 1);
    aux_addr = 9'd0;
    for (int i = 0; i < LS; i++) begin
      @(negedge clk);
      check($sformatf("lat2_d[%0d]", i), 32'(l2_prdata), 32'(3 * i + 5));
      check($sformatf("lat4_d[%0d]", i), 32'(l4_prdata), 32'(3 * i + 5));
      aux_addr = 9'(i + 1);
    end

    // Back-pressure: consumer holds both banks
    base_ack = ack_cnt;
    kick();
    repeat (40) @(negedge clk);
    check("bp_acks", 32'(ack_cnt - base_ack), 2);
    base_all = req_all;
    repeat (20) @(negedge clk);
    check("bp_idle_reqs", 32'(req_all - base_all), 0);
    check("bp_req_low",   32'(fr_next_angle), 0);
    check("bp_valid",     32'(pr_line_valid), 1);
    check("bp_angle",     32'(pr_angle), 0);
    read_line(0, "bp_d0");
    release_line();
    seen = fr_next_angle;
    if (!seen) begin
      @(negedge clk);
      seen = fr_next_angle;
    end
    check("bp_restart", 32'(seen), 1);
    r = cyc;

    // Bank 1 release coincides with bank 0 fill completion, then the reverse
    @(negedge clk);
    read_line(8, "sim_d1");
    wait_until(r + 10);
    pr_line_done = 1'b1;
    wait_until(r + 11);
    pr_line_done = 1'b0;
    check("sim_a_valid", 32'(pr_line_valid), 1);
    check("sim_a_angle", 32'(pr_angle), 90);
    read_line(16, "sim_d2");
    check("sim_req4_cyc", 32'(last_req_cyc - r), 12);
    wait_until(r + 22);
    pr_line_done = 1'b1;
    wait_until(r + 23);
    pr_line_done = 1'b0;
    check("sim_b_valid", 32'(pr_line_valid), 1);
    check("sim_b_angle", 32'(pr_angle), 135);
    read_line(24, "sim_d3");
    release_line();
    n = 0;
    while (!all_done && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("sim_alldone", 32'(all_done), 1);

    // Reset in the middle of a sweep
    kick();
    n = 0;
    while (fr_s_val != 9'd3 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("mid_s3", 32'(fr_s_val), 3);
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_values("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    base_run = req_run;
    kick();
    consume_all("run3");
    check("run3_reqs", 32'(req_run - base_run), 5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
